// File: rtl/inst_encoder.sv
// inst_encoder: packs decoded instruction descriptors into RV32I/Zicsr/mret words,
// queues them and streams them into IMEM. Define INST_ENC_READBACK_EN for write-verify.
module inst_encoder #(
    parameter int unsigned DEPTH     = 4,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  req_class,
    input  logic [3:0]  req_funct,
    input  logic [4:0]  req_rd,
    input  logic [4:0]  req_rs1,
    input  logic [4:0]  req_rs2,
    input  logic [31:0] req_imm,
    output logic        imem_we,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wdata,
    input  logic        imem_ack,
`ifdef INST_ENC_READBACK_EN
    output logic        imem_re,
    input  logic [31:0] imem_rdata,
`endif
    output logic        busy,
    output logic        err,
    output logic [7:0]  err_cnt
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {S_IDLE, S_WRITE, S_RDBK, S_VERIFY} state_e;

    logic [2:0]  f3;
    logic        alt;
    logic        fits_i, fits_b, fits_j, shamt_ok;
    logic [31:0] enc_word_c;
    logic        enc_legal_c;

    assign f3       = req_funct[2:0];
    assign alt      = req_funct[3];
    assign fits_i   = (&req_imm[31:11]) || (req_imm[31:11] == '0);
    assign fits_b   = ((&req_imm[31:12]) || (req_imm[31:12] == '0)) && !req_imm[0];
    assign fits_j   = ((&req_imm[31:20]) || (req_imm[31:20] == '0)) && !req_imm[0];
    assign shamt_ok = (req_imm[31:5] == '0);

    // Combinational descriptor-to-word packing with legality check
    always_comb begin
        enc_word_c  = '0;
        enc_legal_c = 1'b1;
        case (req_class)
            4'd0: begin
                enc_word_c  = {(alt ? 7'h20 : 7'h00), req_rs2, req_rs1, f3, req_rd, 7'h33};
                enc_legal_c = !alt || (f3 == 3'd0) || (f3 == 3'd5);
            end
            4'd1: begin
                if ((f3 == 3'd1) || (f3 == 3'd5)) begin
                    enc_word_c  = {(alt ? 7'h20 : 7'h00), req_imm[4:0], req_rs1, f3, req_rd, 7'h13};
                    enc_legal_c = (!alt || (f3 == 3'd5)) && shamt_ok;
                end else begin
                    enc_word_c  = {req_imm[11:0], req_rs1, f3, req_rd, 7'h13};
                    enc_legal_c = !alt && fits_i;
                end
            end
            4'd2: begin
                enc_word_c  = {req_imm[11:0], req_rs1, f3, req_rd, 7'h03};
                enc_legal_c = fits_i && (f3 != 3'd3) && (f3 != 3'd6) && (f3 != 3'd7);
            end
            4'd3: begin
                enc_word_c  = {req_imm[11:5], req_rs2, req_rs1, f3, req_imm[4:0], 7'h23};
                enc_legal_c = fits_i && (f3 <= 3'd2);
            end
            4'd4: begin
                enc_word_c  = {req_imm[12], req_imm[10:5], req_rs2, req_rs1, f3,
                               req_imm[4:1], req_imm[11], 7'h63};
                enc_legal_c = fits_b && (f3 != 3'd2) && (f3 != 3'd3);
            end
            4'd5, 4'd6: begin
                enc_word_c  = {req_imm[31:12], req_rd, (req_class == 4'd5) ? 7'h37 : 7'h17};
                enc_legal_c = (req_imm[11:0] == '0);
            end
            4'd7: begin
                enc_word_c  = {req_imm[20], req_imm[10:1], req_imm[11], req_imm[19:12], req_rd, 7'h6F};
                enc_legal_c = fits_j;
            end
            4'd8: begin
                enc_word_c  = {req_imm[11:0], req_rs1, 3'd0, req_rd, 7'h67};
                enc_legal_c = fits_i;
            end
            4'd9: begin
                case (req_funct)
                    4'd0:    enc_word_c = 32'h0000_0073;
                    4'd1:    enc_word_c = 32'h0010_0073;
                    4'd2:    enc_word_c = 32'h3020_0073;
                    default: enc_legal_c = 1'b0;
                endcase
            end
            4'd10: begin
                enc_word_c  = {req_imm[11:0], req_rs1, f3, req_rd, 7'h73};
                enc_legal_c = (f3 != 3'd0) && (f3 != 3'd4);
            end
            default: enc_legal_c = 1'b0;
        endcase
    end

    state_e             state_q, state_d;
    logic [31:0]        mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               we_q, we_d, busy_q, err_q;
    logic [31:0]        addr_q, addr_d, wdata_q, wdata_d;
    logic [7:0]         err_cnt_q, err_cnt_d;
    logic               accept_c, push_ok_c, reject_c, push_fifo_c, mismatch_c;
    logic               pop_c, bypass_c, load_c, we_clr_c, addr_inc_c;
    logic [8:0]         err_sum_c;
`ifdef INST_ENC_READBACK_EN
    logic               re_q, re_set_c, re_clr_c, chk_c;
`endif

    // Ready derives from the registered count only, so a pop never frees a slot the same cycle
    assign req_ready   = !rst && (count_q != CNT_W'(DEPTH));
    assign accept_c    = req_valid && req_ready;
    assign push_ok_c   = accept_c && enc_legal_c;
    assign reject_c    = accept_c && !enc_legal_c;
    assign push_fifo_c = push_ok_c && !bypass_c;

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if ((count_q != '0) || push_ok_c) state_d = S_WRITE;
`ifdef INST_ENC_READBACK_EN
            S_WRITE:  if (imem_ack) state_d = S_RDBK;
`else
            S_WRITE:  if (imem_ack) state_d = S_IDLE;
`endif
            S_RDBK:   state_d = S_VERIFY;
            S_VERIFY: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // An empty FIFO lets a fresh descriptor go straight to the write stage
    always_comb begin
        pop_c      = 1'b0;
        bypass_c   = 1'b0;
        load_c     = 1'b0;
        we_clr_c   = 1'b0;
        addr_inc_c = 1'b0;
`ifdef INST_ENC_READBACK_EN
        re_set_c   = 1'b0;
        re_clr_c   = 1'b0;
        chk_c      = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (count_q != '0) begin
                    pop_c  = 1'b1;
                    load_c = 1'b1;
                end else if (push_ok_c) begin
                    bypass_c = 1'b1;
                    load_c   = 1'b1;
                end
            end
            S_WRITE: begin
                if (imem_ack) begin
                    we_clr_c = 1'b1;
`ifdef INST_ENC_READBACK_EN
                    re_set_c = 1'b1;
`else
                    addr_inc_c = 1'b1;
`endif
                end
            end
`ifdef INST_ENC_READBACK_EN
            S_RDBK:   re_clr_c = 1'b1;
            S_VERIFY: begin
                chk_c      = 1'b1;
                addr_inc_c = 1'b1;
            end
`endif
            default: ;
        endcase
    end

`ifdef INST_ENC_READBACK_EN
    assign mismatch_c = chk_c && (imem_rdata != wdata_q);
`else
    assign mismatch_c = 1'b0;
`endif

    always_comb begin
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        if (load_c) begin
            we_d    = 1'b1;
            wdata_d = pop_c ? mem_q[rd_ptr_q] : enc_word_c;
        end
        if (we_clr_c)   we_d   = 1'b0;
        if (addr_inc_c) addr_d = addr_q + 32'd4;
        count_d   = count_q + CNT_W'(push_fifo_c) - CNT_W'(pop_c);
        err_sum_c = {1'b0, err_cnt_q} + 9'(reject_c) + 9'(mismatch_c);
        err_cnt_d = err_sum_c[8] ? 8'hFF : err_sum_c[7:0];
    end

    always_ff @(posedge clk) begin
        if (push_fifo_c) mem_q[wr_ptr_q] <= enc_word_c;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            we_q      <= 1'b0;
            addr_q    <= BASE_ADDR;
            wdata_q   <= '0;
            busy_q    <= 1'b0;
            err_q     <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            if (push_fifo_c) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop_c)       rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q   <= count_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            busy_q    <= (count_d != '0) || (state_d != S_IDLE);
            err_q     <= err_q || reject_c || mismatch_c;
            err_cnt_q <= err_cnt_d;
        end
    end

`ifdef INST_ENC_READBACK_EN
    always_ff @(posedge clk) begin
        if (rst)           re_q <= 1'b0;
        else if (re_set_c) re_q <= 1'b1;
        else if (re_clr_c) re_q <= 1'b0;
    end
    assign imem_re = re_q;
`endif

    assign imem_we    = we_q;
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;
    assign busy       = busy_q;
    assign err        = err_q;
    assign err_cnt    = err_cnt_q;
endmodule

// File: tb/tb_inst_encoder.sv
// Directed self-checking bench for inst_encoder; honours INST_ENC_READBACK_EN.
module tb_inst_encoder;
    localparam int unsigned DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [3:0]  req_class = '0;
    logic [3:0]  req_funct = '0;
    logic [4:0]  req_rd = '0, req_rs1 = '0, req_rs2 = '0;
    logic [31:0] req_imm = '0;
    logic        imem_we;
    logic [31:0] imem_addr, imem_wdata;
    logic        imem_ack = 1'b0;
    logic        busy, err;
    logic [7:0]  err_cnt;
`ifdef INST_ENC_READBACK_EN
    logic        imem_re;
    logic [31:0] imem_rdata;
    logic [31:0] wr_last = '0;
    logic        corrupt = 1'b0;
    always @(posedge clk) if (imem_we && imem_ack) wr_last <= imem_wdata;
    assign imem_rdata = corrupt ? ~wr_last : wr_last;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    inst_encoder #(.DEPTH(DEPTH), .BASE_ADDR(32'h0000_0000)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_class(req_class), .req_funct(req_funct),
        .req_rd(req_rd), .req_rs1(req_rs1), .req_rs2(req_rs2), .req_imm(req_imm),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata), .imem_ack(imem_ack),
`ifdef INST_ENC_READBACK_EN
        .imem_re(imem_re), .imem_rdata(imem_rdata),
`endif
        .busy(busy), .err(err), .err_cnt(err_cnt)
    );

    // Drive one descriptor and hold it until accepted (bounded)
    task automatic send(input logic [3:0] cls, input logic [3:0] fn, input logic [4:0] rd,
                        input logic [4:0] rs1, input logic [4:0] rs2, input logic [31:0] imm,
                        output bit ok);
        req_class = cls; req_funct = fn; req_rd = rd; req_rs1 = rs1; req_rs2 = rs2; req_imm = imm;
        req_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (req_ready) begin
                ok = 1'b1;
                @(posedge clk); #1;
                break;
            end
            @(posedge clk); #1;
        end
        req_valid = 1'b0;
    endtask

    // Wait for a write strobe (bounded), capture it, acknowledge for one cycle
    task automatic get_write(output logic [31:0] addr, output logic [31:0] data, output bit ok);
        ok = 1'b0; addr = '0; data = '0;
        for (int i = 0; i < 50; i++) begin
            if (imem_we) begin
                ok = 1'b1;
                addr = imem_addr;
                data = imem_wdata;
                break;
            end
            @(posedge clk); #1;
        end
        if (ok) begin
            imem_ack = 1'b1;
            @(posedge clk); #1;
            imem_ack = 1'b0;
        end
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if (req_ready !== 1'b0) begin n_bad++; $display("FAIL ready_in_rst got=%b want=0", req_ready); end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        apply_reset();
        n_cmp += 7;
        if (req_ready !== 1'b1)    begin n_bad++; $display("FAIL rst_ready got=%b want=1", req_ready); end
        if (imem_we !== 1'b0)      begin n_bad++; $display("FAIL rst_we got=%b want=0", imem_we); end
        if (imem_addr !== 32'h0)   begin n_bad++; $display("FAIL rst_addr got=%h want=0", imem_addr); end
        if (imem_wdata !== 32'h0)  begin n_bad++; $display("FAIL rst_wdata got=%h want=0", imem_wdata); end
        if (busy !== 1'b0)         begin n_bad++; $display("FAIL rst_busy got=%b want=0", busy); end
        if (err !== 1'b0)          begin n_bad++; $display("FAIL rst_err got=%b want=0", err); end
        if (err_cnt !== 8'd0)      begin n_bad++; $display("FAIL rst_errcnt got=%0d want=0", err_cnt); end
    endtask

    task automatic test_single();
        bit ok;
        apply_reset();
        send(4'd0, 4'd0, 5'd3, 5'd1, 5'd2, 32'd0, ok);
        n_cmp += 5;
        if (!ok)                         begin n_bad++; $display("FAIL add_accept got=0 want=1"); end
        if (imem_we !== 1'b1)            begin n_bad++; $display("FAIL add_latency we got=%b want=1", imem_we); end
        if (imem_addr !== 32'h0)         begin n_bad++; $display("FAIL add_addr got=%h want=0", imem_addr); end
        if (imem_wdata !== 32'h002081B3) begin n_bad++; $display("FAIL add_word got=%h want=002081b3", imem_wdata); end
        if (busy !== 1'b1)               begin n_bad++; $display("FAIL add_busy got=%b want=1", busy); end
        imem_ack = 1'b1;
        @(posedge clk); #1;
        imem_ack = 1'b0;
        n_cmp++;
        if (imem_we !== 1'b0) begin n_bad++; $display("FAIL add_we_drop got=%b want=0", imem_we); end
        repeat (4) @(posedge clk);
        #1;
        n_cmp += 2;
        if (imem_addr !== 32'h4) begin n_bad++; $display("FAIL add_next_addr got=%h want=4", imem_addr); end
        if (busy !== 1'b0)       begin n_bad++; $display("FAIL add_idle_busy got=%b want=0", busy); end
    endtask

    task automatic test_sub_addi();
        bit ok, okw;
        logic [31:0] a, d;
        logic [31:0] exp_w [2] = '{32'h402081B3, 32'h00500093};
        apply_reset();
        send(4'd0, 4'd8, 5'd3, 5'd1, 5'd2, 32'd0, ok);
        send(4'd1, 4'd0, 5'd1, 5'd0, 5'd0, 32'd5, ok);
        for (int i = 0; i < 2; i++) begin
            get_write(a, d, okw);
            n_cmp += 2;
            if (!okw || a !== 32'(4 * i)) begin n_bad++; $display("FAIL subaddi_addr[%0d] got=%h want=%h", i, a, 32'(4 * i)); end
            if (!okw || d !== exp_w[i])   begin n_bad++; $display("FAIL subaddi_word[%0d] got=%h want=%h", i, d, exp_w[i]); end
        end
    endtask

    task automatic test_mix();
        bit ok, okw;
        logic [31:0] a, d;
        logic [31:0] exp_w [4] = '{32'h00812283, 32'hFE208EE3, 32'h123452B7, 32'h00000073};
        apply_reset();
        send(4'd2, 4'd2, 5'd5, 5'd2, 5'd0, 32'd8, ok);
        send(4'd4, 4'd0, 5'd0, 5'd1, 5'd2, 32'hFFFF_FFFC, ok);
        send(4'd5, 4'd0, 5'd5, 5'd0, 5'd0, 32'h1234_5000, ok);
        send(4'd9, 4'd0, 5'd0, 5'd0, 5'd0, 32'd0, ok);
        for (int i = 0; i < 4; i++) begin
            get_write(a, d, okw);
            n_cmp += 2;
            if (!okw || a !== 32'(4 * i)) begin n_bad++; $display("FAIL mix_addr[%0d] got=%h want=%h", i, a, 32'(4 * i)); end
            if (!okw || d !== exp_w[i])   begin n_bad++; $display("FAIL mix_word[%0d] got=%h want=%h", i, d, exp_w[i]); end
        end
    endtask

    task automatic test_back_to_back();
        bit ok, okw;
        logic [31:0] a, d, w;
        apply_reset();
        for (int k = 1; k <= int'(DEPTH) + 1; k++) begin
            send(4'd1, 4'd0, 5'd1, 5'd0, 5'd0, 32'(k), ok);
            n_cmp++;
            if (!ok) begin n_bad++; $display("FAIL bp_accept[%0d] got=0 want=1", k); end
        end
        req_valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            n_cmp++;
            if (req_ready !== 1'b0) begin n_bad++; $display("FAIL bp_full_ready[%0d] got=%b want=0", c, req_ready); end
            @(posedge clk); #1;
        end
        req_valid = 1'b0;
        for (int k = 1; k <= int'(DEPTH) + 1; k++) begin
            get_write(a, d, okw);
            w = (32'(k) << 20) | 32'h0000_0093;
            n_cmp += 2;
            if (!okw || a !== 32'(4 * (k - 1))) begin n_bad++; $display("FAIL bp_addr[%0d] got=%h want=%h", k, a, 32'(4 * (k - 1))); end
            if (!okw || d !== w)                begin n_bad++; $display("FAIL bp_word[%0d] got=%h want=%h", k, d, w); end
        end
        repeat (6) @(posedge clk);
        #1;
        n_cmp += 2;
        if (imem_we !== 1'b0) begin n_bad++; $display("FAIL bp_extra_write got=%b want=0", imem_we); end
        if (busy !== 1'b0)    begin n_bad++; $display("FAIL bp_drain_busy got=%b want=0", busy); end
    endtask

    task automatic test_reject();
        bit ok, okw;
        logic [31:0] a, d;
        apply_reset();
        send(4'd2, 4'd3, 5'd1, 5'd2, 5'd0, 32'd0, ok);
        send(4'd4, 4'd0, 5'd0, 5'd1, 5'd2, 32'd3, ok);
        send(4'd1, 4'd0, 5'd1, 5'd0, 5'd0, 32'd2048, ok);
        repeat (2) @(posedge clk);
        #1;
        n_cmp += 4;
        if (imem_we !== 1'b0)  begin n_bad++; $display("FAIL rej_we got=%b want=0", imem_we); end
        if (busy !== 1'b0)     begin n_bad++; $display("FAIL rej_busy got=%b want=0", busy); end
        if (err !== 1'b1)      begin n_bad++; $display("FAIL rej_err got=%b want=1", err); end
        if (err_cnt !== 8'd3)  begin n_bad++; $display("FAIL rej_errcnt got=%0d want=3", err_cnt); end
        send(4'd1, 4'd0, 5'd2, 5'd0, 5'd0, 32'd7, ok);
        get_write(a, d, okw);
        n_cmp += 3;
        if (!okw || a !== 32'h0)         begin n_bad++; $display("FAIL rej_next_addr got=%h want=0", a); end
        if (!okw || d !== 32'h00700113)  begin n_bad++; $display("FAIL rej_next_word got=%h want=00700113", d); end
        if (err !== 1'b1)                begin n_bad++; $display("FAIL rej_sticky got=%b want=1", err); end
    endtask

    task automatic test_boundary();
        bit ok, okw;
        logic [31:0] a, d;
        logic [31:0] exp_w [2] = '{32'h80000093, 32'h7FFFF0EF};
        apply_reset();
        send(4'd1, 4'd0, 5'd1, 5'd0, 5'd0, 32'hFFFF_F800, ok);
        send(4'd7, 4'd0, 5'd1, 5'd0, 5'd0, 32'h000F_FFFE, ok);
        send(4'd7, 4'd0, 5'd1, 5'd0, 5'd0, 32'h0010_0000, ok);
        send(4'd11, 4'd0, 5'd1, 5'd0, 5'd0, 32'd0, ok);
        send(4'd5, 4'd0, 5'd1, 5'd0, 5'd0, 32'h0000_1001, ok);
        for (int i = 0; i < 2; i++) begin
            get_write(a, d, okw);
            n_cmp += 2;
            if (!okw || a !== 32'(4 * i)) begin n_bad++; $display("FAIL bnd_addr[%0d] got=%h want=%h", i, a, 32'(4 * i)); end
            if (!okw || d !== exp_w[i])   begin n_bad++; $display("FAIL bnd_word[%0d] got=%h want=%h", i, d, exp_w[i]); end
        end
        repeat (6) @(posedge clk);
        #1;
        n_cmp += 2;
        if (err_cnt !== 8'd3) begin n_bad++; $display("FAIL bnd_errcnt got=%0d want=3", err_cnt); end
        if (imem_we !== 1'b0) begin n_bad++; $display("FAIL bnd_extra_write got=%b want=0", imem_we); end
    endtask

    task automatic test_reset_mid_write();
        bit ok, okw;
        logic [31:0] a, d;
        apply_reset();
        send(4'd0, 4'd0, 5'd3, 5'd1, 5'd2, 32'd0, ok);
        send(4'd0, 4'd0, 5'd4, 5'd1, 5'd2, 32'd0, ok);
        n_cmp++;
        if (imem_we !== 1'b1) begin n_bad++; $display("FAIL rmw_we_pre got=%b want=1", imem_we); end
        rst = 1'b1;
        @(posedge clk); #1;
        n_cmp += 3;
        if (imem_we !== 1'b0)   begin n_bad++; $display("FAIL rmw_we got=%b want=0", imem_we); end
        if (busy !== 1'b0)      begin n_bad++; $display("FAIL rmw_busy got=%b want=0", busy); end
        if (req_ready !== 1'b0) begin n_bad++; $display("FAIL rmw_ready got=%b want=0", req_ready); end
        rst = 1'b0;
        @(posedge clk); #1;
        n_cmp++;
        if (imem_we !== 1'b0) begin n_bad++; $display("FAIL rmw_flush got=%b want=0", imem_we); end
        send(4'd1, 4'd0, 5'd1, 5'd0, 5'd0, 32'd5, ok);
        get_write(a, d, okw);
        n_cmp += 2;
        if (!okw || a !== 32'h0)        begin n_bad++; $display("FAIL rmw_addr got=%h want=0", a); end
        if (!okw || d !== 32'h00500093) begin n_bad++; $display("FAIL rmw_word got=%h want=00500093", d); end
    endtask

`ifdef INST_ENC_READBACK_EN
    task automatic test_readback();
        bit ok, okw;
        logic [31:0] a, d;
        apply_reset();
        send(4'd0, 4'd0, 5'd3, 5'd1, 5'd2, 32'd0, ok);
        get_write(a, d, okw);
        repeat (4) @(posedge clk);
        #1;
        n_cmp += 3;
        if (err !== 1'b0)        begin n_bad++; $display("FAIL rb_clean_err got=%b want=0", err); end
        if (imem_addr !== 32'h4) begin n_bad++; $display("FAIL rb_addr got=%h want=4", imem_addr); end
        if (busy !== 1'b0)       begin n_bad++; $display("FAIL rb_busy got=%b want=0", busy); end
        corrupt = 1'b1;
        send(4'd0, 4'd0, 5'd3, 5'd1, 5'd2, 32'd0, ok);
        get_write(a, d, okw);
        repeat (4) @(posedge clk);
        #1;
        corrupt = 1'b0;
        n_cmp += 2;
        if (err !== 1'b1)     begin n_bad++; $display("FAIL rb_err got=%b want=1", err); end
        if (err_cnt !== 8'd1) begin n_bad++; $display("FAIL rb_errcnt got=%0d want=1", err_cnt); end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_sub_addi();
        test_mix();
        test_back_to_back();
        test_reject();
        test_boundary();
        test_reset_mid_write();
`ifdef INST_ENC_READBACK_EN
        test_readback();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
